pll_lock_controller: RTL and testbench



---
 rtl/pll_lock_controller_if.sv | 36 +++
 rtl/pll_lock_controller.sv | 205 ++++++++++++++++++++
 tb/tb_pll_lock_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_controller_if.sv
// pll_lock_controller_if
//   Groups the request, lock and status signals between the PLL lock
//   controller and its environment. CLK and RESET stay plain ports on the
//   controller and are not part of this interface.
//
//   START      level request to bring the PLL up and keep it up
//   LOCK       raw PLL lock, asynchronous to CLK
//   PLL_EN     enable to the PLL primitive
//   READY      PLL locked and qualified
//   FAIL       retries exhausted (sticky until START low or RESET)
//   LOCK_LOST  one-cycle pulse on loss of qualified lock
//   RETRY_CNT  retries used in the current bring-up sequence
//   STATE      controller state encoding
//
//   slave  : used by the controller
//   master : used by whatever drives START/LOCK and observes the status
interface pll_lock_controller_if;
  logic       START;
  logic       LOCK;
  logic       PLL_EN;
  logic       READY;
  logic       FAIL;
  logic       LOCK_LOST;
  logic [7:0] RETRY_CNT;
  logic [2:0] STATE;

  modport master (
    output START, LOCK,
    input  PLL_EN, READY, FAIL, LOCK_LOST, RETRY_CNT, STATE
  );

  modport slave (
    input  START, LOCK,
    output PLL_EN, READY, FAIL, LOCK_LOST, RETRY_CNT, STATE
  );
endinterface

// File: rtl/pll_lock_controller.sv
// pll_lock_controller
//   Sequences PLL enable and lock on the free-running reference clock:
//   per-attempt lock timeout, bounded retry with PLL_EN off-time between
//   attempts, lock-stability qualification and loss-of-lock detection.
//
//   Optional feature macro: PLL_LOCK_CTRL_AUTO_RELOCK_EN
//     defined     : loss of qualified lock restarts the retry sequence
//     not defined : loss of qualified lock is terminal (FAILED)
//
//   Ports
//     CLK    free-running reference clock
//     RESET  synchronous, active-high reset
//     bus    pll_lock_controller_if.slave (START, LOCK in; status out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | START low, PLL held off
//   EN_WAIT | PLL_EN high, waiting for synchronized lock, timer running
//   STABLE  | lock seen, counting consecutive lock cycles, timer running
//   LOCKED  | lock qualified, READY high, timer frozen
//   BACKOFF | PLL_EN low for OFF_CYCLES between attempts
//   FAILED  | retries exhausted or lock lost; waits for START low/RESET
module pll_lock_controller #(
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int MAX_RETRIES        = 3,
  parameter int OFF_CYCLES         = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  pll_lock_controller_if.slave   bus
);

  localparam int TMR_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int OFF_W = $clog2(OFF_CYCLES) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_DONE  = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(OFF_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EN_WAIT = 3'd1,
    S_STABLE  = 3'd2,
    S_LOCKED  = 3'd3,
    S_BACKOFF = 3'd4,
    S_FAILED  = 3'd5
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic             pll_en_r;
  logic             ready_r;
  logic             fail_r;
  logic             lock_lost_r;
  logic [7:0]       retry_cnt;
  logic [TMR_W-1:0] timer;
  logic [STB_W-1:0] stable_cnt;
  logic [OFF_W-1:0] off_cnt;

  logic timeout;
  logic retries_spent;

  assign timeout       = (timer == TMR_LAST);
  assign retries_spent = (retry_cnt == RETRY_MAX);

  always_ff @(posedge CLK) begin
    lock_lost_r <= 1'b0;
    if (RESET) begin
      state      <= S_IDLE;
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      pll_en_r   <= 1'b0;
      ready_r    <= 1'b0;
      fail_r     <= 1'b0;
      retry_cnt  <= '0;
      timer      <= '0;
      stable_cnt <= '0;
      off_cnt    <= '0;
    end else begin
      lock_meta <= bus.LOCK;
      lock_s    <= lock_meta;
      if (!bus.START) begin
        // Requested shutdown: not a loss of lock, so no LOCK_LOST pulse.
        state      <= S_IDLE;
        pll_en_r   <= 1'b0;
        ready_r    <= 1'b0;
        fail_r     <= 1'b0;
        retry_cnt  <= '0;
        timer      <= '0;
        stable_cnt <= '0;
        off_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_EN_WAIT;
            pll_en_r <= 1'b1;
            timer    <= '0;
          end

          S_EN_WAIT: begin
            timer <= timer + 1'b1;
            if (lock_s) begin
              state      <= S_STABLE;
              stable_cnt <= STB_W'(1);
            end else if (timeout) begin
              pll_en_r <= 1'b0;
              if (retries_spent) begin
                state  <= S_FAILED;
                fail_r <= 1'b1;
              end else begin
                state     <= S_BACKOFF;
                retry_cnt <= retry_cnt + 1'b1;
                off_cnt   <= '0;
              end
            end
          end

          S_STABLE: begin
            timer <= timer + 1'b1;
            // Completion is checked before timeout so a lock that qualifies
            // on the last cycle of the attempt is kept.
            if (lock_s && (stable_cnt == STB_DONE)) begin
              state   <= S_LOCKED;
              ready_r <= 1'b1;
            end else if (timeout) begin
              pll_en_r <= 1'b0;
              if (retries_spent) begin
                state  <= S_FAILED;
                fail_r <= 1'b1;
              end else begin
                state     <= S_BACKOFF;
                retry_cnt <= retry_cnt + 1'b1;
                off_cnt   <= '0;
              end
            end else if (lock_s) begin
              stable_cnt <= stable_cnt + 1'b1;
            end else begin
              state <= S_EN_WAIT;
            end
          end

          S_LOCKED: begin
            if (!lock_s) begin
              lock_lost_r <= 1'b1;
              ready_r     <= 1'b0;
              pll_en_r    <= 1'b0;
`ifdef PLL_LOCK_CTRL_AUTO_RELOCK_EN
              // Fresh retry sequence; the BACKOFF entry itself counts as
              // retry 1, unless no retries are allowed at all.
              if (MAX_RETRIES == 0) begin
                state     <= S_FAILED;
                fail_r    <= 1'b1;
                retry_cnt <= '0;
              end else begin
                state     <= S_BACKOFF;
                retry_cnt <= 8'd1;
                off_cnt   <= '0;
              end
`else
              state     <= S_FAILED;
              fail_r    <= 1'b1;
              retry_cnt <= '0;
`endif
            end
          end

          S_BACKOFF: begin
            if (off_cnt == OFF_LAST) begin
              state    <= S_EN_WAIT;
              pll_en_r <= 1'b1;
              timer    <= '0;
            end else begin
              off_cnt <= off_cnt + 1'b1;
            end
          end

          S_FAILED: begin
            pll_en_r <= 1'b0;
            fail_r   <= 1'b1;
            ready_r  <= 1'b0;
          end

          default: begin
            state    <= S_IDLE;
            pll_en_r <= 1'b0;
            ready_r  <= 1'b0;
            fail_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.PLL_EN    = pll_en_r;
  assign bus.READY     = ready_r;
  assign bus.FAIL      = fail_r;
  assign bus.LOCK_LOST = lock_lost_r;
  assign bus.RETRY_CNT = retry_cnt;
  assign bus.STATE     = state;

endmodule

// File: tb/tb_pll_lock_controller.sv
module tb_pll_lock_controller;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pll_lock_controller_if pif ();

  pll_lock_controller #(
    .LOCK_TIMEOUT      (100),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2),
    .OFF_CYCLES        (4)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(pif.STATE), 0);
    chk({tag, "_pll_en"}, 32'(pif.PLL_EN), 0);
    chk({tag, "_ready"}, 32'(pif.READY), 0);
    chk({tag, "_fail"}, 32'(pif.FAIL), 0);
    chk({tag, "_lock_lost"}, 32'(pif.LOCK_LOST), 0);
    chk({tag, "_retry"}, 32'(pif.RETRY_CNT), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic exp_en;
    logic exp_fail;
    int   exp_retry;
    total = 0;
    bad   = 0;

    // 1: reset with START and LOCK high
    rst = 1'b1;
    pif.START = 1'b1;
    pif.LOCK  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rst");
    end
    rst = 1'b0;
    pif.LOCK = 1'b0;
    tick();
    chk("rst_rel_pll_en", 32'(pif.PLL_EN), 1);
    chk("rst_rel_state", 32'(pif.STATE), 1);

    // 2: lock 20 cycles after PLL_EN, READY on 10th edge after first sample
    repeat (19) tick();
    chk("pre_lock_state", 32'(pif.STATE), 1);
    pif.LOCK = 1'b1;
    repeat (10) tick();
    chk("ready_early", 32'(pif.READY), 0);
    tick();
    chk("ready_rise", 32'(pif.READY), 1);
    chk("locked_state", 32'(pif.STATE), 3);
    chk("locked_retry", 32'(pif.RETRY_CNT), 0);
    chk("locked_pll_en", 32'(pif.PLL_EN), 1);

    // 5: loss of lock while LOCKED
    repeat (3) tick();
    chk("hold_ready", 32'(pif.READY), 1);
    pif.LOCK = 1'b0;
    tick();
    tick();
    chk("ll_early", 32'(pif.LOCK_LOST), 0);
    chk("ll_ready_early", 32'(pif.READY), 1);
    tick();
    chk("ll_pulse", 32'(pif.LOCK_LOST), 1);
    chk("ll_ready_fall", 32'(pif.READY), 0);
    chk("ll_pll_en", 32'(pif.PLL_EN), 0);
`ifdef PLL_LOCK_CTRL_AUTO_RELOCK_EN
    chk("ll_state", 32'(pif.STATE), 4);
    chk("ll_retry", 32'(pif.RETRY_CNT), 1);
    pif.LOCK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ll_off_pll_en", 32'(pif.PLL_EN), 0);
      chk("ll_pulse_end", 32'(pif.LOCK_LOST), 0);
    end
    tick();
    chk("ll_reen_pll_en", 32'(pif.PLL_EN), 1);
    chk("ll_reen_retry", 32'(pif.RETRY_CNT), 1);
    n = 0;
    while (!pif.READY && n < 40) begin
      tick();
      n++;
    end
    chk("relock_ready", 32'(pif.READY), 1);
    chk("relock_state", 32'(pif.STATE), 3);
`else
    chk("ll_state", 32'(pif.STATE), 5);
    chk("ll_fail", 32'(pif.FAIL), 1);
    chk("ll_retry", 32'(pif.RETRY_CNT), 0);
    pif.LOCK = 1'b1;
    tick();
    chk("ll_pulse_end", 32'(pif.LOCK_LOST), 0);
    repeat (5) tick();
    chk("ll_fail_hold", 32'(pif.FAIL), 1);
    chk("ll_state_hold", 32'(pif.STATE), 5);
    chk("ll_pll_en_hold", 32'(pif.PLL_EN), 0);
`endif
    pif.START = 1'b0;
    pif.LOCK  = 1'b0;
    tick();
    chk_idle("stop1");

    // 3: no lock at all, three attempts then FAIL
    pif.START = 1'b1;
    for (int i = 1; i <= 320; i++) begin
      tick();
      exp_en    = (i <= 100) || (i >= 105 && i <= 204) || (i >= 209 && i <= 308);
      exp_fail  = (i >= 309);
      exp_retry = (i <= 100) ? 0 : ((i <= 204) ? 1 : 2);
      chk($sformatf("to_pll_en_%0d", i), 32'(pif.PLL_EN), 32'(exp_en));
      chk($sformatf("to_fail_%0d", i), 32'(pif.FAIL), 32'(exp_fail));
      chk($sformatf("to_retry_%0d", i), 32'(pif.RETRY_CNT), 32'(exp_retry));
    end
    chk("to_state", 32'(pif.STATE), 5);
    pif.START = 1'b0;
    tick();
    chk_idle("stop2");

    // 4: lock glitch, then steady lock
    pif.START = 1'b1;
    tick();
    pif.LOCK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gl_ready_hi", 32'(pif.READY), 0);
    end
    chk("gl_stable_state", 32'(pif.STATE), 2);
    pif.LOCK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gl_ready_lo", 32'(pif.READY), 0);
    end
    chk("gl_back_state", 32'(pif.STATE), 1);
    pif.LOCK = 1'b1;
    repeat (10) tick();
    chk("gl_ready_early", 32'(pif.READY), 0);
    tick();
    chk("gl_ready_rise", 32'(pif.READY), 1);
    chk("gl_locked_state", 32'(pif.STATE), 3);
    pif.START = 1'b0;
    pif.LOCK  = 1'b0;
    tick();
    chk_idle("stop3");

    // 6: START dropped mid EN_WAIT on the second attempt
    pif.START = 1'b1;
    repeat (154) tick();
    chk("sd_state", 32'(pif.STATE), 1);
    chk("sd_retry", 32'(pif.RETRY_CNT), 1);
    pif.START = 1'b0;
    tick();
    chk_idle("sd");
    pif.START = 1'b1;
    tick();
    chk("sd_restart_state", 32'(pif.STATE), 1);
    chk("sd_restart_pll_en", 32'(pif.PLL_EN), 1);
    chk("sd_restart_retry", 32'(pif.RETRY_CNT), 0);
    repeat (99) tick();
    chk("sd_full_attempt", 32'(pif.PLL_EN), 1);
    tick();
    chk("sd_attempt_end", 32'(pif.PLL_EN), 0);
    chk("sd_attempt_retry", 32'(pif.RETRY_CNT), 1);

    // mid-operation reset
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk_idle("mid_rst");
    rst = 1'b0;
    tick();
    chk("mid_rst_rel_pll_en", 32'(pif.PLL_EN), 1);
    chk("mid_rst_rel_retry", 32'(pif.RETRY_CNT), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
